// File: rtl/pc_gen_pkg.sv
// ----------------------------------------------------------------------------
// pc_gen_pkg
// Shared types and constants for the program-counter generator.
//   redirect_kind_t : how an EXEC instruction wants to change the PC
//   fsm_state_t     : sequencing state of the PC generator
//   DEFAULT_*       : default reset vector and exit (halt) address
//   link_offset()   : distance from the current PC to the return address
// ----------------------------------------------------------------------------
package pc_gen_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,  // no redirect
        KIND_REG  = 2'b01,  // JR / JALR: target comes from rs
        KIND_PAGE = 2'b10,  // J / JAL: 26-bit index inside current 256 MB page
        KIND_REL  = 2'b11   // conditional branches: PC-relative
    } redirect_kind_t;

    typedef enum logic [1:0] {
        FSM_RUN  = 2'b00,   // normal sequential execution
        FSM_SLOT = 2'b01,   // executing a delay-slot instruction, target queued
        FSM_HALT = 2'b10    // stopped until reset
    } fsm_state_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;

    // Width of the in-page part of a page-absolute jump target.
    localparam int PAGE_BITS = 28;

    // With a delay slot the return address skips the slot instruction too.
    function automatic logic [31:0] link_offset(input int delay_slot);
        return (delay_slot != 0) ? 32'd8 : 32'd4;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// ----------------------------------------------------------------------------
// pc_target_calc
// Purely combinational next-PC arithmetic.
//   addr        in  ADDR_W  current PC
//   kind        in  2       redirect kind
//   instr_low   in  26      low 26 bits of the registered instruction
//   reg_q       in  ADDR_W  registered rs value
//   seq         out ADDR_W  addr + 4 (wraps)
//   target      out ADDR_W  redirect target for 'kind' (seq for KIND_NONE)
// ----------------------------------------------------------------------------
module pc_target_calc
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  redirect_kind_t    kind,
    input  logic [25:0]       instr_low,
    input  logic [ADDR_W-1:0] reg_q,
    output logic [ADDR_W-1:0] seq,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] page_target;
    logic [ADDR_W-1:0] rel_offset;
    logic [ADDR_W-1:0] rel_target;

    // Page-absolute keeps the upper bits of seq (nothing above bit 27 when
    // ADDR_W is 28) and replaces the in-page part with the scaled index.
    // The branch offset is a word offset, sign-extended after scaling by 4.
    always_comb begin
        seq         = addr + ADDR_W'(4);
        page_target = seq;
        page_target[PAGE_BITS-1:0] = {instr_low, 2'b00};
        rel_offset  = {{(ADDR_W-18){instr_low[15]}}, instr_low[15:0], 2'b00};
        rel_target  = seq + rel_offset;
        unique case (kind)
            KIND_REG:  target = reg_q;
            KIND_PAGE: target = page_target;
            KIND_REL:  target = rel_target;
            default:   target = seq;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen
// Program-counter generator for a two-phase (FETCH/EXEC) MIPS-style core,
// with optional branch delay slot, halt-on-exit-address and misaligned
// register-jump detection.
//   clk            in  1       clock, all state on rising edge
//   reset_n        in  1       synchronous active-low reset (beats stall)
//   state          in  1       0 = FETCH (capture), 1 = EXEC (update)
//   stall          in  1       freeze all registers
//   redirect_valid in  1       EXEC instruction redirects
//   redirect_kind  in  2       see redirect_kind_t
//   instr_word     in  32      fetched instruction
//   reg_data       in  ADDR_W  rs value for register jumps
//   addr           out ADDR_W  current PC
//   link_addr      out ADDR_W  return address
//   active         out 1       CPU running
//   delay_pending  out 1       executing a delay slot with a redirect queued
//   addr_err       out 1       sticky misaligned register-jump flag
// ----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_VEC  = DEFAULT_RESET_VEC,
    parameter logic [31:0] HALT_ADDR  = DEFAULT_HALT_ADDR,
    parameter int          DELAY_SLOT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              state,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_kind,
    input  logic [31:0]       instr_word,
    input  logic [ADDR_W-1:0] reg_data,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] link_addr,
    output logic              active,
    output logic              delay_pending,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] RST_PC   = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXIT_PC  = HALT_ADDR[ADDR_W-1:0];
    localparam logic [31:0]       LINK_OFF = link_offset(DELAY_SLOT);

    if (ADDR_W < 28 || ADDR_W > 32) begin : g_bad_addr_w
        $error("pc_gen: ADDR_W must be in 28..32");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_state_t        fsm, fsm_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [ADDR_W-1:0] target_q, target_nx;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] reg_q;
    logic              active_q, active_nx;
    logic              err_q, err_nx;

    redirect_kind_t    kind;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] target;
    logic              capture;
    logic              update;
    logic              redirect;
    logic              misaligned;
    logic              unused_instr_hi;

    assign kind     = redirect_kind_t'(redirect_kind);
    assign capture  = !state && !stall;
    assign update   = state && !stall;
    assign redirect = redirect_valid && (kind != KIND_NONE);

    // Only register jumps can produce a misaligned target; page and
    // relative targets are always word-aligned by construction.
    assign misaligned = (kind == KIND_REG) && (reg_q[1:0] != 2'b00);

    // The opcode/register fields of the instruction never affect the PC.
    assign unused_instr_hi = ^instr_q[31:26];

    pc_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .addr      (pc),
        .kind      (kind),
        .instr_low (instr_q[25:0]),
        .reg_q     (reg_q),
        .seq       (seq),
        .target    (target)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Nothing moves except on an update edge; the halt
    // check comes first so reaching the exit address wins over both a
    // new redirect and a queued delay-slot target.
    // ------------------------------------------------------------------
    always_comb begin
        fsm_nx    = fsm;
        pc_nx     = pc;
        target_nx = target_q;
        active_nx = active_q;
        err_nx    = err_q;
        unique case (fsm)
            FSM_RUN: begin
                if (update) begin
                    if (pc == EXIT_PC) begin
                        fsm_nx    = FSM_HALT;
                        active_nx = 1'b0;
                    end else if (redirect && misaligned) begin
                        fsm_nx    = FSM_HALT;
                        active_nx = 1'b0;
                        err_nx    = 1'b1;
                    end else if (redirect && (DELAY_SLOT != 0)) begin
                        pc_nx     = seq;
                        target_nx = target;
                        fsm_nx    = FSM_SLOT;
                    end else if (redirect) begin
                        pc_nx     = target;
                    end else begin
                        pc_nx     = seq;
                    end
                end
            end
            FSM_SLOT: begin
                // Redirects requested by the slot instruction are dropped.
                if (update) begin
                    if (pc == EXIT_PC) begin
                        fsm_nx    = FSM_HALT;
                        active_nx = 1'b0;
                    end else begin
                        pc_nx     = target_q;
                        fsm_nx    = FSM_RUN;
                    end
                end
            end
            default: begin
                fsm_nx = FSM_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset beats stall; the operand capture is suppressed in
    // HALT so a halted core ignores its inputs entirely.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm      <= FSM_RUN;
            pc       <= RST_PC;
            target_q <= '0;
            instr_q  <= '0;
            reg_q    <= '0;
            active_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            fsm      <= fsm_nx;
            pc       <= pc_nx;
            target_q <= target_nx;
            active_q <= active_nx;
            err_q    <= err_nx;
            if (capture && (fsm != FSM_HALT)) begin
                instr_q <= instr_word;
                reg_q   <= reg_data;
            end
        end
    end

    assign addr          = pc;
    assign link_addr     = pc + LINK_OFF[ADDR_W-1:0];
    assign active        = active_q;
    assign delay_pending = (fsm == FSM_SLOT);
    assign addr_err      = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen
// Directed bench for pc_gen. Two instances: index 0 uses a delay slot,
// index 1 redirects immediately. Stimulus queues the expected outputs;
// a monitor on the falling edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset_n_s        [2];
    logic        state_s          [2];
    logic        stall_s          [2];
    logic        redirect_valid_s [2];
    logic [1:0]  redirect_kind_s  [2];
    logic [31:0] instr_word_s     [2];
    logic [31:0] reg_data_s       [2];
    logic [31:0] addr_s           [2];
    logic [31:0] link_s           [2];
    logic        active_s         [2];
    logic        dp_s             [2];
    logic        err_s            [2];

    typedef struct {
        int          d;
        string       name;
        logic [31:0] addr;
        logic        act;
        logic        dp;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .DELAY_SLOT(1)) dut_ds (
        .clk            (clk),
        .reset_n        (reset_n_s[0]),
        .state          (state_s[0]),
        .stall          (stall_s[0]),
        .redirect_valid (redirect_valid_s[0]),
        .redirect_kind  (redirect_kind_s[0]),
        .instr_word     (instr_word_s[0]),
        .reg_data       (reg_data_s[0]),
        .addr           (addr_s[0]),
        .link_addr      (link_s[0]),
        .active         (active_s[0]),
        .delay_pending  (dp_s[0]),
        .addr_err       (err_s[0])
    );

    pc_gen #(.ADDR_W(32), .DELAY_SLOT(0)) dut_im (
        .clk            (clk),
        .reset_n        (reset_n_s[1]),
        .state          (state_s[1]),
        .stall          (stall_s[1]),
        .redirect_valid (redirect_valid_s[1]),
        .redirect_kind  (redirect_kind_s[1]),
        .instr_word     (instr_word_s[1]),
        .reg_data       (reg_data_s[1]),
        .addr           (addr_s[1]),
        .link_addr      (link_s[1]),
        .active         (active_s[1]),
        .delay_pending  (dp_s[1]),
        .addr_err       (err_s[1])
    );

    // Monitor: every expectation queued after an edge is checked at the
    // following falling edge, including the link address derived from the
    // expected PC.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] exp_link;
            e = sb.pop_front();
            exp_link = e.addr + ((e.d == 0) ? 32'd8 : 32'd4);
            tests_run++;
            if (addr_s[e.d] !== e.addr || link_s[e.d] !== exp_link ||
                active_s[e.d] !== e.act || dp_s[e.d] !== e.dp ||
                err_s[e.d] !== e.err) begin
                tests_failed++;
                $display("[TB] FAIL %s (dut%0d): got addr=%h link=%h active=%b dp=%b err=%b, want addr=%h link=%h active=%b dp=%b err=%b",
                         e.name, e.d, addr_s[e.d], link_s[e.d], active_s[e.d],
                         dp_s[e.d], err_s[e.d], e.addr, exp_link, e.act,
                         e.dp, e.err);
            end
        end
    end

    task automatic applyStimulus(input int d, input logic rst_n,
                                 input logic st, input logic stl,
                                 input logic rv, input logic [1:0] kind,
                                 input logic [31:0] iw,
                                 input logic [31:0] rd);
        reset_n_s[d]        = rst_n;
        state_s[d]          = st;
        stall_s[d]          = stl;
        redirect_valid_s[d] = rv;
        redirect_kind_s[d]  = kind;
        instr_word_s[d]     = iw;
        reg_data_s[d]       = rd;
        @(posedge clk);
        #1;
        // Park the instance so it cannot move while the other one runs.
        stall_s[d]   = 1'b1;
        reset_n_s[d] = 1'b1;
    endtask

    task automatic checkOutput(input int d, input string name,
                               input logic [31:0] a, input logic act,
                               input logic dp, input logic err);
        exp_t e;
        e.d = d; e.name = name; e.addr = a;
        e.act = act; e.dp = dp; e.err = err;
        sb.push_back(e);
    endtask

    task automatic doReset(input int d, input logic st, input logic stl);
        applyStimulus(d, 1'b0, st, stl, 1'b1, 2'b01, 32'h1234_5678, 32'h0000_0003);
    endtask

    task automatic doFetch(input int d, input logic [31:0] iw, input logic [31:0] rd);
        applyStimulus(d, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, iw, rd);
    endtask

    // Live instr/reg inputs during EXEC are junk (misaligned reg value) so
    // any use of unregistered operands shows up.
    task automatic doExec(input int d, input logic rv, input logic [1:0] kind);
        applyStimulus(d, 1'b1, 1'b1, 1'b0, rv, kind, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    endtask

    task automatic stepPlain(input int d);
        doFetch(d, 32'h0, 32'h0);
        doExec(d, 1'b0, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset_n_s[i] = 1'b1; state_s[i] = 1'b0; stall_s[i] = 1'b1;
            redirect_valid_s[i] = 1'b0; redirect_kind_s[i] = 2'b00;
            instr_word_s[i] = 32'h0; reg_data_s[i] = 32'h0;
        end

        // ---------------- delay-slot instance ----------------
        doReset(0, 1'b0, 1'b0);
        checkOutput(0, "reset", 32'hBFC0_0000, 1, 0, 0);
        doFetch(0, 32'h0, 32'h0);
        checkOutput(0, "fetch_holds", 32'hBFC0_0000, 1, 0, 0);
        doExec(0, 1'b0, 2'b00);
        checkOutput(0, "seq1", 32'hBFC0_0004, 1, 0, 0);
        stepPlain(0);
        checkOutput(0, "seq2", 32'hBFC0_0008, 1, 0, 0);
        stepPlain(0);
        checkOutput(0, "seq3", 32'hBFC0_000C, 1, 0, 0);
        stepPlain(0);
        checkOutput(0, "seq4", 32'hBFC0_0010, 1, 0, 0);

        // BEQ +3 words: slot at BFC00014, target BFC00014 + 0xC.
        doFetch(0, 32'h1000_0003, 32'h0);
        doExec(0, 1'b1, 2'b11);
        checkOutput(0, "beq_slot", 32'hBFC0_0014, 1, 1, 0);
        doFetch(0, 32'h0, 32'h0000_0003);
        doExec(0, 1'b1, 2'b01);
        checkOutput(0, "beq_target_slot_redirect_ignored", 32'hBFC0_0020, 1, 0, 0);

        // Backward branch -2 words, then stall 5 cycles in the slot.
        doFetch(0, 32'h1000_FFFE, 32'h0);
        doExec(0, 1'b1, 2'b11);
        checkOutput(0, "bwd_slot", 32'hBFC0_0024, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b1, logic'(i % 2), 1'b1, 1'b1, 2'b01,
                          32'h1000_0100, 32'h1234_5670);
            checkOutput(0, "stall_in_slot", 32'hBFC0_0024, 1, 1, 0);
        end
        stepPlain(0);
        checkOutput(0, "after_stall_target", 32'hBFC0_001C, 1, 0, 0);

        // Jump to the exit address, then halt and stay halted.
        doFetch(0, 32'h0, 32'h0);
        doExec(0, 1'b1, 2'b01);
        checkOutput(0, "jr0_slot", 32'hBFC0_0020, 1, 1, 0);
        stepPlain(0);
        checkOutput(0, "at_exit", 32'h0000_0000, 1, 0, 0);
        doFetch(0, 32'h1000_0003, 32'h0);
        doExec(0, 1'b1, 2'b11);
        checkOutput(0, "halted", 32'h0000_0000, 0, 0, 0);
        doFetch(0, 32'h0, 32'h0040_0000);
        doExec(0, 1'b1, 2'b01);
        checkOutput(0, "halt_absorbing", 32'h0000_0000, 0, 0, 0);
        doReset(0, 1'b1, 1'b1);
        checkOutput(0, "reset_from_halt", 32'hBFC0_0000, 1, 0, 0);

        // Reset in SLOT discards the queued target.
        doFetch(0, 32'h0, 32'h0040_0000);
        doExec(0, 1'b1, 2'b01);
        checkOutput(0, "queued_before_reset", 32'hBFC0_0004, 1, 1, 0);
        doReset(0, 1'b1, 1'b0);
        checkOutput(0, "reset_in_slot", 32'hBFC0_0000, 1, 0, 0);
        stepPlain(0);
        checkOutput(0, "queue_discarded", 32'hBFC0_0004, 1, 0, 0);

        // Page-absolute J from AFFFFFFC: seq crosses into page B.
        doReset(0, 1'b0, 1'b0);
        doFetch(0, 32'h0, 32'hAFFF_FFFC);
        doExec(0, 1'b1, 2'b01);
        checkOutput(0, "jr_far_slot", 32'hBFC0_0004, 1, 1, 0);
        stepPlain(0);
        checkOutput(0, "at_affffffc", 32'hAFFF_FFFC, 1, 0, 0);
        doFetch(0, 32'h0800_0010, 32'h0);
        doExec(0, 1'b1, 2'b10);
        checkOutput(0, "j_slot", 32'hB000_0000, 1, 1, 0);
        stepPlain(0);
        checkOutput(0, "j_target", 32'hB000_0040, 1, 0, 0);

        // Wrap from FFFFFFFC to 0, then halt at the exit address.
        doFetch(0, 32'h0, 32'hFFFF_FFFC);
        doExec(0, 1'b1, 2'b01);
        checkOutput(0, "jr_top_slot", 32'hB000_0044, 1, 1, 0);
        stepPlain(0);
        checkOutput(0, "at_top", 32'hFFFF_FFFC, 1, 0, 0);
        stepPlain(0);
        checkOutput(0, "wrap_to_zero", 32'h0000_0000, 1, 0, 0);
        stepPlain(0);
        checkOutput(0, "wrap_halt", 32'h0000_0000, 0, 0, 0);

        // ---------------- immediate-redirect instance ----------------
        doReset(1, 1'b1, 1'b1);
        checkOutput(1, "reset_over_stall", 32'hBFC0_0000, 1, 0, 0);
        doFetch(1, 32'h0, 32'h0040_0000);
        doExec(1, 1'b1, 2'b01);
        checkOutput(1, "jr_immediate", 32'h0040_0000, 1, 0, 0);

        // A stalled FETCH must not overwrite the captured rs value.
        doFetch(1, 32'h0, 32'h0040_0008);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0800_0001, 32'h0040_0002);
        checkOutput(1, "stalled_fetch", 32'h0040_0000, 1, 0, 0);
        doExec(1, 1'b1, 2'b01);
        checkOutput(1, "jr_uses_reg_q", 32'h0040_0008, 1, 0, 0);

        doFetch(1, 32'h1000_0003, 32'h0);
        doExec(1, 1'b1, 2'b11);
        checkOutput(1, "beq_immediate", 32'h0040_0018, 1, 0, 0);
        doFetch(1, 32'h1000_0003, 32'h0);
        doExec(1, 1'b1, 2'b00);
        checkOutput(1, "kind_none", 32'h0040_001C, 1, 0, 0);
        doFetch(1, 32'h1000_0003, 32'h0);
        doExec(1, 1'b0, 2'b11);
        checkOutput(1, "valid_low", 32'h0040_0020, 1, 0, 0);

        doFetch(1, 32'h0, 32'h0040_0002);
        doExec(1, 1'b1, 2'b01);
        checkOutput(1, "misaligned_jr", 32'h0040_0020, 0, 0, 1);
        stepPlain(1);
        checkOutput(1, "err_sticky", 32'h0040_0020, 0, 0, 1);
        doReset(1, 1'b1, 1'b1);
        checkOutput(1, "reset_clears_err", 32'hBFC0_0000, 1, 0, 0);

        @(negedge clk);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
